wb_slave_splitter: RTL and testbench

- Shares the single user-area Wishbone slave port (wbs_*) between NSLAVE user peripherals.
- Decodes the address window and forwards one transaction at a time to the selected peripheral.
- Returns that peripheral's ack/data upstream and terminates unmapped or hung accesses cleanly.
- Sits directly under user_project_wrapper, between the wbs_* pins and the peripheral blocks.

---
 rtl/wb_slave_splitter.sv | 97 +++++++++
 tb/tb_wb_slave_splitter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_splitter.sv
// wb_slave_splitter: shares the wbs_* Wishbone slave port among NSLAVE peripherals (clk wb_clk_i, sync rst wb_rst_i; in wbs_cyc/stb/we/sel/adr/dat, m_ack_i, m_dat_i; out registered wbs_ack_o/wbs_dat_o, one-hot m_cyc_o/m_stb_o, latched m_we/sel/adr/dat, sticky timeout_o); define WB_SPLIT_TIMEOUT_EN to terminate hung slaves after TIMEOUT cycles
module wb_slave_splitter #(
  parameter int NSLAVE = 4,
  parameter int IDX_BITS = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NSLAVE-1:0]        m_cyc_o,
  output logic [NSLAVE-1:0]        m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [31:0]              m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic [NSLAVE-1:0]        m_ack_i,
  input  logic [32*NSLAVE-1:0]     m_dat_i,
  output logic                     timeout_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic req, hit, mapped, acked, timed_out;
  logic [IDX_BITS-1:0] idx;
  logic [NSLAVE-1:0] onehot, cyc_nxt;
  logic [31:0] rdata, dat_nxt;
  assign req = wbs_cyc_i & wbs_stb_i;
  assign idx = wbs_adr_i[12+IDX_BITS-1:12];
  assign hit = wbs_adr_i[31:16] == BASE_ADDR[31:16];
  assign mapped = hit && (int'(idx) < NSLAVE);
  assign onehot = NSLAVE'(1) << idx;
  assign acked = |(m_ack_i & m_cyc_o);
  assign m_stb_o = m_cyc_o;
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NSLAVE; k++) rdata = rdata | (m_cyc_o[k] ? m_dat_i[32*k +: 32] : 32'h0);
  end
`ifdef WB_SPLIT_TIMEOUT_EN
  logic [15:0] cnt;
  assign timed_out = cnt + 16'd1 == 16'(TIMEOUT);
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 16'd1 : '0;
      if (state == WAIT && state_nxt == RESP && !acked) timeout_o <= 1'b1;
      else if (state == IDLE && req && hit && idx == '1 && wbs_we_i) timeout_o <= 1'b0;
    end
`else
  assign timed_out = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req ? (mapped ? WAIT : RESP) : IDLE;
      WAIT:    state_nxt = !wbs_cyc_i ? IDLE : (acked || timed_out) ? RESP : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    cyc_nxt = (state == IDLE && req && mapped) ? onehot : (state == WAIT && state_nxt == WAIT) ? m_cyc_o : '0;
    dat_nxt = state_nxt != RESP ? 32'h0 :
              state == IDLE ? (wbs_we_i ? 32'h0 : 32'hBADD_ADD0) :
              acked ? (m_we_o ? 32'h0 : rdata) : 32'hFFFF_FFFF;
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o <= '0;
      m_we_o <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else begin
      state <= state_nxt;
      wbs_ack_o <= state_nxt == RESP;
      wbs_dat_o <= dat_nxt;
      m_cyc_o <= cyc_nxt;
      if (state == IDLE && req) begin
        m_we_o <= wbs_we_i;
        m_sel_o <= wbs_sel_i;
        m_adr_o <= wbs_adr_i;
        m_dat_o <= wbs_dat_i;
      end
    end
endmodule

// File: tb/tb_wb_slave_splitter.sv
// tb_wb_slave_splitter: table, directed and random checks of wb_slave_splitter against a transaction-level model
module tb_wb_slave_splitter;
`ifdef WB_SPLIT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int LIMIT = 400;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic ack;
  logic [31:0] rdat;
  logic [3:0] m_cyc, m_stb, m_ack = '0;
  logic m_we;
  logic [3:0] m_sel;
  logic [31:0] m_adr, m_dat;
  logic [127:0] m_rdat = '0;
  logic tmo;
  int n_cmp = 0, n_fail = 0;

  wb_slave_splitter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(m_ack), .m_dat_i(m_rdat),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] sdat;
    int          lat;
    logic [31:0] edat;
    logic [3:0]  stb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: which slave is addressed, when the ack comes back, what data it carries.
  function automatic void model(input logic [31:0] a, input logic w, input int dly, input logic [127:0] sd,
                                output int lat, output logic [31:0] d, output logic [3:0] s);
    int i;
    i = int'(a[14:12]);
    if (a[31:16] != 16'h3000 || i >= 4) begin
      lat = 1;
      d = w ? 32'h0 : 32'hBADD_ADD0;
      s = 4'b0;
    end else begin
      lat = 2 + dly;
      d = w ? 32'h0 : sd[32*i +: 32];
      s = 4'(1 << i);
    end
  endfunction

  // dly >= 0: each strobed slave acks from the (dly+1)th strobe cycle on; dly < 0: never acks.
  task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s,
                     input int dly, input logic [127:0] sd, input int e_lat, input logic [31:0] e_dat, input logic [3:0] e_stb);
    int lat;
    logic [31:0] got;
    lat = -1;
    got = '0;
    m_rdat = sd;
    m_ack = '0;
    @(negedge clk);
    adr = a; wdat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= LIMIT; c++) begin
      #1;
      m_ack = ((dly >= 0 && c > dly) ? m_stb : 4'b0) | (4'($urandom) & ~m_stb);
      @(negedge clk);
      if (c == 1) begin
        chk({nm, "_stb"}, 32'(m_stb), 32'(e_stb));
        chk({nm, "_adr"}, m_adr, a);
        chk({nm, "_wdat"}, m_dat, d);
        chk({nm, "_we_sel"}, {27'b0, m_we, m_sel}, {27'b0, w, s});
      end
      if (ack) begin
        lat = c;
        got = rdat;
        break;
      end
      @(posedge clk);
    end
    chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
    chk({nm, "_dat"}, got, e_dat);
    m_ack = '0;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk({nm, "_post"}, {rdat[30:0], ack, m_stb != 4'b0}, 33'b0 == 33'b0 ? 32'h0 : 32'h0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [127:0] sd;
    logic [31:0] r_adr, r_dat, e_dat;
    logic r_we;
    logic [3:0] r_sel, e_stb;
    int r_dly, e_lat;
    tbl[0] = '{32'h3000_2000, 32'h0,         1'b0, 4'hF,    3, 32'h1234_5678, 5, 32'h1234_5678, 4'b0100};
    tbl[1] = '{32'h3000_0004, 32'hA5A5_A5A5, 1'b1, 4'b0011, 0, 32'h5555_0000, 2, 32'h0,         4'b0001};
    tbl[2] = '{32'h3000_5000, 32'h0,         1'b0, 4'hF,    0, 32'h0,         1, 32'hBADD_ADD0, 4'b0000};
    tbl[3] = '{32'h2000_0000, 32'h0,         1'b0, 4'hF,    0, 32'h0,         1, 32'hBADD_ADD0, 4'b0000};
    tbl[4] = '{32'h3000_4000, 32'h1111_2222, 1'b1, 4'hC,    0, 32'h0,         1, 32'h0,         4'b0000};
    tbl[5] = '{32'h3000_3FFC, 32'h0,         1'b0, 4'hF,    1, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 4'b1000};
    tbl[6] = '{32'h3000_8000, 32'h0,         1'b0, 4'h1,    2, 32'h0BAD_CAFE, 4, 32'h0BAD_CAFE, 4'b0001};
    tbl[7] = '{32'h3001_1000, 32'h0,         1'b0, 4'hF,    0, 32'h0,         1, 32'hBADD_ADD0, 4'b0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_dat", {rdat[30:0], ack}, 32'h0);
    chk("rst_cyc_stb", {24'b0, m_cyc, m_stb}, 32'h0);
    chk("rst_we_sel_tmo", {26'b0, tmo, m_we, m_sel}, 32'h0);
    chk("rst_adr", m_adr, 32'h0);
    chk("rst_wdat", m_dat, 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < 4; k++) sd[32*k +: 32] = tbl[i].stb[k] ? tbl[i].sdat : ~tbl[i].sdat;
      txn($sformatf("vec%0d", i), tbl[i].adr, tbl[i].dat, tbl[i].we, tbl[i].sel, tbl[i].dly, sd,
          tbl[i].lat, tbl[i].edat, tbl[i].stb);
    end

    // held request: no re-accept while the ack is being returned
    @(negedge clk);
    adr = 32'h3000_5000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("held_ack", {rdat, ack} == {32'hBADD_ADD0, 1'b1}, 32'h1);
    @(negedge clk);
    chk("held_no_reaccept", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("held_idle", 32'(ack), 32'h0);

    // hung slave 1
    sd = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    txn("hung", 32'h3000_1000, 32'h0, 1'b0, 4'hF, TMO ? -1 : 300, sd,
        TMO ? 256 : 302, TMO ? 32'hFFFF_FFFF : 32'h1111_1111, 4'b0010);
    chk("tmo_set", 32'(tmo), 32'(TMO));
    txn("sticky", 32'h3000_0000, 32'h0, 1'b0, 4'hF, 1, sd, 3, 32'h0, 4'b0001);
    chk("tmo_sticky", 32'(tmo), 32'(TMO));
    txn("tclr", 32'h3000_7000, 32'h1, 1'b1, 4'hF, 0, sd, 1, 32'h0, 4'b0000);
    chk("tmo_clear", 32'(tmo), 32'h0);
    txn("hung2", 32'h3000_1000, 32'h0, 1'b0, 4'hF, TMO ? -1 : 300, sd,
        TMO ? 256 : 302, TMO ? 32'hFFFF_FFFF : 32'h1111_1111, 4'b0010);

    // reset while waiting on slave 2
    @(negedge clk);
    adr = 32'h3000_2010; wdat = 32'hDEAD_BEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("rw_stb", 32'(m_stb), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_ack_dat", {rdat[30:0], ack}, 32'h0);
    chk("rw_cyc_stb", {24'b0, m_cyc, m_stb}, 32'h0);
    chk("rw_we_sel_tmo", {26'b0, tmo, m_we, m_sel}, 32'h0);
    chk("rw_adr", m_adr, 32'h0);
    chk("rw_wdat", m_dat, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; m_ack = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rw_late_ack", 32'(ack), 32'h0);
    end
    m_ack = '0;

    // master abandons the cycle while waiting on slave 1
    @(negedge clk);
    adr = 32'h3000_1000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("drop_stb_on", 32'(m_stb), 32'h2);
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("drop_stb_off", {31'b0, ack}, 32'h0);
    chk("drop_stb_low", 32'(m_stb), 32'h0);
    m_ack = 4'b0010;
    repeat (2) @(negedge clk);
    chk("drop_no_ack", 32'(ack), 32'h0);
    m_ack = '0;
    sd = {32'h7777_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    txn("after_drop", 32'h3000_3000, 32'h0, 1'b0, 4'hF, 0, sd, 2, 32'h7777_3333, 4'b1000);

    for (int i = 0; i < 60; i++) begin
      r_adr = {($urandom_range(0, 99) < 85) ? 16'h3000 : 16'($urandom), 1'($urandom), 3'($urandom), 12'($urandom)};
      r_dat = $urandom;
      r_we = 1'($urandom);
      r_sel = 4'($urandom);
      r_dly = $urandom_range(0, 6);
      for (int k = 0; k < 4; k++) sd[32*k +: 32] = $urandom;
      model(r_adr, r_we, r_dly, sd, e_lat, e_dat, e_stb);
      txn($sformatf("rnd%0d", i), r_adr, r_dat, r_we, r_sel, r_dly, sd, e_lat, e_dat, e_stb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
